divide_unit: RTL and testbench

- Sequential fixed-point divider; the inverse operation to the ALU's combinational sign-magnitude multiply path.
- Uses the same 16-bit sign-magnitude Q7.8 operand format: bit 15 is the sign, bits 14:0 are the magnitude, with 8 fractional bits.
- Computes c = a / b with a restoring shift-subtract loop, one quotient bit per cycle.
- Uses a start/busy/done handshake so the ALU issue logic can stall on it.
- Reports the same flag set as the multiply path (cout, zero, overflow, neg).

---
 rtl/divide_unit.sv | 134 +++++++++++++
 tb/tb_divide_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/divide_unit.sv
// Sequential sign-magnitude Q7.8 divider: restoring shift-subtract, one quotient
// bit per cycle, start/busy/done handshake and multiply-compatible flags.
module divide_unit #(
  parameter int N    = 32,
  parameter int FRAC = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] c,
  output logic         cout,
  output logic         zero,
  output logic         overflow,
  output logic         neg
);

  localparam int ITER = 15 + FRAC;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [15:0]     c_q;

  logic            sign_q;
  logic [ITER-1:0] dvd_q;
  logic [14:0]     dsr_q;
  logic [14:0]     rem_q;
  logic [ITER-1:0] quo_q;

  logic [15:0]     rem_sh;
  logic            ge;
  logic [15:0]     rem_nx;
  logic [ITER-1:0] quo_nx;
  logic            capture;

  // Upper operand bits carry no data.
  logic unused_hi;
  assign unused_hi = ^{a[N-1:16], b[N-1:16]};

  function automatic logic quo_ovf(input logic [ITER-1:0] q);
    return |q[ITER-1:15];
  endfunction

  function automatic logic [14:0] sat_mag(input logic [ITER-1:0] q);
    return quo_ovf(q) ? 15'h7FFF : q[14:0];
  endfunction

  assign capture = start && (state != DIV);

  always_comb begin
    rem_sh = {rem_q, dvd_q[ITER-1]};
    ge     = (rem_sh >= {1'b0, dsr_q});
    rem_nx = ge ? (rem_sh - {1'b0, dsr_q}) : rem_sh;
    quo_nx = {quo_q[ITER-2:0], ge};
  end

  // Datapath registers: loaded at capture, stepped once per DIV cycle.
  always_ff @(posedge clk) begin
    if (capture) begin
      sign_q <= a[15] ^ b[15];
      dvd_q  <= {a[14:0], {FRAC{1'b0}}};
      dsr_q  <= b[14:0];
      rem_q  <= '0;
      quo_q  <= '0;
    end else if (state == DIV) begin
      rem_q  <= rem_nx[14:0];
      quo_q  <= quo_nx;
      dvd_q  <= {dvd_q[ITER-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      c_q      <= '0;
      cout     <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      neg      <= 1'b0;
    end else begin
      case (state)
        DIV: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            c_q      <= {sign_q, sat_mag(quo_nx)};
            overflow <= quo_ovf(quo_nx);
            cout     <= |rem_nx;
            zero     <= (sat_mag(quo_nx) == 15'd0);
            neg      <= sign_q;
          end
        end
        default: begin
          if (start) begin
            cnt <= CW'(ITER);
            // A zero divisor magnitude finishes immediately with a saturated result.
            if (b[14:0] == 15'd0) begin
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              c_q      <= {a[15] ^ b[15], 15'h7FFF};
              overflow <= 1'b1;
              cout     <= 1'b0;
              zero     <= 1'b0;
              neg      <= a[15] ^ b[15];
            end else begin
              state <= DIV;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign c = {{(N-16){1'b0}}, c_q};

endmodule

// File: tb/tb_divide_unit.sv
// Directed bench for divide_unit: hand-computed Q7.8 quotients, handshake
// timing, divide-by-zero, ignored start, back-to-back and mid-operation reset.
module tb_divide_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] c;
  logic        cout;
  logic        zero;
  logic        overflow;
  logic        neg;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int nbusy;
  int ndone;

  divide_unit #(.N(32), .FRAC(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .c(c), .cout(cout), .zero(zero),
    .overflow(overflow), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one edge, then scramble them.
  task automatic launch(input logic [31:0] aa, input logic [31:0] bb);
    @(negedge clk);
    a = aa; b = bb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 32'h1234_5A5A;
    b = 32'h0000_0003;
  endtask

  // Called in cycle t+1; returns the cycle index of done (0 on timeout).
  task automatic wait_done(input int inj_k, input logic [31:0] ia, input logic [31:0] ib,
                           output int l, output int nb);
    l = 0;
    nb = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        l = k;
        break;
      end
      if (busy) nb++;
      if (k == inj_k) begin
        a = ia; b = ib; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] ec, input logic ecout,
                              input logic ezero, input logic eovf, input logic eneg);
    check({tag, "_c"}, c, ec);
    check({tag, "_cout"}, cout, ecout);
    check({tag, "_zero"}, zero, ezero);
    check({tag, "_ovf"}, overflow, eovf);
    check({tag, "_neg"}, neg, eneg);
    check({tag, "_busy_at_done"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check_result("rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 1.5 / 0.5 = 3.0
    launch(32'h0000_0180, 32'h0000_0080);
    check("basic_busy_t1", busy, 1'b1);
    wait_done(0, '0, '0, lat, nbusy);
    check("basic_lat", lat, 24);
    check("basic_nbusy", nbusy, 23);
    check_result("basic", 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("basic_done_pulse", done, 1'b0);
    check("basic_hold_c", c, 32'h0000_0300);

    // -2.0 / 0.5 = -4.0
    launch(32'h0000_8200, 32'h0000_0080);
    wait_done(0, '0, '0, lat, nbusy);
    check("sneg_lat", lat, 24);
    check_result("sneg", 32'h0000_8400, 1'b0, 1'b0, 1'b0, 1'b1);

    // 1.0 / 3.0 = 0x55 truncated, inexact
    launch(32'h0000_0100, 32'h0000_0300);
    wait_done(0, '0, '0, lat, nbusy);
    check_result("third", 32'h0000_0055, 1'b1, 1'b0, 1'b0, 1'b0);

    // 127.0 / (1/256) saturates
    launch(32'h0000_7F00, 32'h0000_0001);
    wait_done(0, '0, '0, lat, nbusy);
    check_result("ovf", 32'h0000_7FFF, 1'b0, 1'b0, 1'b1, 1'b0);

    // tiny / huge underflows to zero with remainder
    launch(32'h0000_0001, 32'h0000_7FFF);
    wait_done(0, '0, '0, lat, nbusy);
    check_result("under", 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);

    // divide by -0
    launch(32'h0000_0100, 32'h0000_8000);
    wait_done(0, '0, '0, lat, nbusy);
    check("dz_lat", lat, 1);
    check("dz_nbusy", nbusy, 0);
    check_result("dz", 32'h0000_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);

    // start pulse while busy is ignored
    launch(32'h0000_0180, 32'h0000_0080);
    wait_done(5, 32'h0000_0100, 32'h0000_0300, lat, nbusy);
    check("ign_lat", lat, 24);
    check_result("ign", 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0);

    // upper operand bits ignored, then back-to-back capture in the done cycle
    launch(32'hFFFF_8200, 32'hFFFF_0080);
    wait_done(0, '0, '0, lat, nbusy);
    check("hi_lat", lat, 24);
    check_result("hi", 32'h0000_8400, 1'b0, 1'b0, 1'b0, 1'b1);
    a = 32'h0000_0100; b = 32'h0000_0300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_low", done, 1'b0);
    check("b2b_busy_t1", busy, 1'b1);
    wait_done(0, '0, '0, lat, nbusy);
    check("b2b_lat", lat, 24);
    check_result("b2b", 32'h0000_0055, 1'b1, 1'b0, 1'b0, 1'b0);

    // reset at t+10 aborts the operation
    launch(32'h0000_0180, 32'h0000_0080);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_busy", busy, 1'b0);
    check("mid_done", done, 1'b0);
    check_result("mid", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mid_no_done", ndone, 0);
    launch(32'h0000_8200, 32'h0000_0080);
    wait_done(0, '0, '0, lat, nbusy);
    check("fresh_lat", lat, 24);
    check_result("fresh", 32'h0000_8400, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
